maze_game_ctrl: RTL and testbench
=================================

// Module: maze_game_ctrl
// PURPOSE
//  Parametrised maze-game controller: menu -> show-map countdown -> play -> won/lost.
//  Moves the player one tile per direction pulse, checks walls through a 1-cycle-latency map ROM port, counts wall strikes.
//  Sits between the debounced-button block (SCEN pulses) and the VGA renderer, which consumes player position and show_map.
// PARAMETERS
//  MAP_W        30           map columns; ROM row width in bits
//  MAP_H        21           map rows; ROM depth
//  START_X      0            player column after reset/start
//  START_Y      11           player row after reset/start
//  GOAL_X       29           goal column
//  GOAL_Y       9            goal row
//  MAX_STRIKES  3            wall strikes that cause a loss (>=1)
//  SHOW_EASY    500_000_000  show-map cycles, difficulty 0
//  SHOW_MED     250_000_000  show-map cycles, difficulty 1
//  SHOW_HARD    100_000_000  show-map cycles, difficulty 2 and 3
// PORTS
//  clk         in   1               single system clock; all logic on posedge
//  reset       in   1               synchronous, active-low reset
//  start       in   1               1-cycle pulse: start game (MENU) / return to menu (WON, LOST)
//  difficulty  in   2               sampled only on the accepted start pulse
//  scen        in   4               1-cycle move pulses: [0] up, [1] down, [2] left, [3] right
//  map_addr    out  $clog2(MAP_H)   ROM row address
//  map_row     in   MAP_W           ROM data, valid 1 cycle after map_addr; bit[x]=1 is a wall
//  player_x    out  $clog2(MAP_W)   player column
//  player_y    out  $clog2(MAP_H)   player row
//  show_map    out  1               high while the maze is displayed (SHOW state)
//  game_state  out  3               MENU=0, SHOW=1, PLAY=2, WON=3, LOST=4
//  strikes     out  $clog2(MAX_STRIKES+1)  wall strikes this game
//  won, lost   out  1               level outputs, high in WON / LOST
// BEHAVIOUR
//  Reset (reset==0 at posedge): state MENU, player=(START_X,START_Y), strikes=0, timer=0,
//   map_addr=0, show_map=0, won=lost=0, move sub-FSM IDLE; any in-flight lookup is discarded.
//  MENU: start -> SHOW; latch difficulty, load timer with SHOW_* - 1, reset player/strikes. scen ignored.
//  SHOW: show_map=1; timer decrements each cycle; timer==0 -> PLAY next edge (exactly SHOW_* cycles in SHOW).
//   scen and start ignored.
//  PLAY move sub-FSM IDLE -> WAIT -> CHECK:
//   IDLE: any scen bit -> pick one by priority up>down>left>right; compute target tile.
//    Target out of range (x<0, x>MAP_W-1, y<0, y>MAP_H-1) -> pulse dropped, no strike, stay IDLE.
//    Else register target, drive map_addr=target_y, -> WAIT.
//   WAIT: one cycle for ROM latency -> CHECK.
//   CHECK: map_row[target_x]==1 -> strikes+1, position unchanged; else player<=target.
//    Returns to IDLE. Position updates on the 3rd posedge after the edge sampling scen (IDLE, WAIT, CHECK).
//   scen pulses arriving in WAIT/CHECK are dropped (no queue).
//   Commit onto (GOAL_X,GOAL_Y) -> WON on the same edge. Strike reaching MAX_STRIKES -> LOST on the same edge.
//   Wall and goal cannot coincide; the goal tile is never a wall in the map file.
//  WON / LOST: position, strikes frozen; start -> MENU (player/strikes reset on entry to MENU).
//  start in PLAY is ignored.
//  Width rules: targets computed one bit wider than position to detect underflow/overflow.
//   strikes saturates at MAX_STRIKES. Timer width = $clog2(max SHOW_*)+1.
//  Outputs registered; no combinational path from scen/start to any output.
// STRUCTURE
//  maze_pkg: game_state and move-state encodings, direction index constants (DIR_UP..DIR_RIGHT).
//  Sub-module maze_countdown (load, load_val, zero flag) implements the show-map timer.
//  ROM stays outside this block; the top level muxes map_addr with the renderer's address (game has priority in PLAY).
// TESTING  (bench params: MAP_W=8, MAP_H=6, START=(0,3), GOAL=(7,3), MAX_STRIKES=2, SHOW_*=10/5/2; 1-cycle behavioural ROM)
//  1. reset low 2 cycles mid-SHOW -> state MENU, player (0,3), show_map=0, strikes 0.
//  2. start with difficulty=1 -> show_map high exactly 5 cycles, then game_state=2.
//  3. right pulse into open tile (1,3) -> player_x=1 on 3rd edge after pulse; up pulse at y=0 -> dropped, strikes 0.
//  4. two right pulses into wall at (2,3) -> strikes 1 then 2, lost=1, game_state=4; later scen ignored.
//  5. up+left pulse in same cycle -> only up applied; right pulse during WAIT -> dropped.
//  6. walk open path to (7,3) -> won=1 on the commit edge; start -> MENU, player (0,3), strikes 0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared encodings for the maze game controller: game/move state enums,
// direction bit indices of the move-pulse bus, and a width helper.
package maze_pkg;

  typedef enum logic [2:0] {
    GS_MENU = 3'd0,
    GS_SHOW = 3'd1,
    GS_PLAY = 3'd2,
    GS_WON  = 3'd3,
    GS_LOST = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    MV_IDLE  = 2'd0,
    MV_WAIT  = 2'd1,
    MV_CHECK = 2'd2
  } move_state_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/maze_countdown.sv
// Loadable down-counter for the show-map phase; zero_o flags the final cycle.
module maze_countdown #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: menu -> timed map preview -> play -> won/lost.
// Each accepted move pulse looks up the target row in an external 1-cycle ROM.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int MAP_W       = 30,
  parameter int MAP_H       = 21,
  parameter int START_X     = 0,
  parameter int START_Y     = 11,
  parameter int GOAL_X      = 29,
  parameter int GOAL_Y      = 9,
  parameter int MAX_STRIKES = 3,
  parameter int SHOW_EASY   = 500_000_000,
  parameter int SHOW_MED    = 250_000_000,
  parameter int SHOW_HARD   = 100_000_000,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H),
  localparam int SW = $clog2(MAX_STRIKES + 1),
  localparam int TW = $clog2(max3(SHOW_EASY, SHOW_MED, SHOW_HARD)) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       difficulty,
  input  logic [3:0]       scen,
  output logic [YW-1:0]    map_addr,
  input  logic [MAP_W-1:0] map_row,
  output logic [XW-1:0]    player_x,
  output logic [YW-1:0]    player_y,
  output logic             show_map,
  output logic [2:0]       game_state,
  output logic [SW-1:0]    strikes,
  output logic             won,
  output logic             lost,
  output logic [1:0]       move_state_dbg
);

  localparam logic [XW:0]   X_LAST  = (XW + 1)'(MAP_W - 1);
  localparam logic [YW:0]   Y_LAST  = (YW + 1)'(MAP_H - 1);
  localparam logic [SW-1:0] STR_MAX = SW'(MAX_STRIKES);

  game_state_t   state_q, state_d;
  move_state_t   mv_q, mv_d;
  logic [XW-1:0] px_q, px_d, tx_q, tx_d;
  logic [YW-1:0] py_q, py_d, ty_q, ty_d;
  logic [YW-1:0] addr_q, addr_d;
  logic [SW-1:0] str_q, str_d;
  logic          show_q, won_q, lost_q;

  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_load_val;

  logic [XW:0]   cand_x;
  logic [YW:0]   cand_y;
  logic          cand_ok;

  maze_countdown #(.W(TW)) u_countdown (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  // Target is one bit wider so a step off either edge shows up as > LAST.
  always_comb begin
    cand_x = {1'b0, px_q};
    cand_y = {1'b0, py_q};
    if (scen[DIR_UP]) begin
      cand_y = cand_y - 1'b1;
    end else if (scen[DIR_DOWN]) begin
      cand_y = cand_y + 1'b1;
    end else if (scen[DIR_LEFT]) begin
      cand_x = cand_x - 1'b1;
    end else if (scen[DIR_RIGHT]) begin
      cand_x = cand_x + 1'b1;
    end
    cand_ok = (scen != 4'd0) && (cand_x <= X_LAST) && (cand_y <= Y_LAST);
  end

  always_comb begin
    case (difficulty)
      2'd0:    tmr_load_val = TW'(SHOW_EASY - 1);
      2'd1:    tmr_load_val = TW'(SHOW_MED - 1);
      default: tmr_load_val = TW'(SHOW_HARD - 1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    px_d     = px_q;
    py_d     = py_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    addr_d   = addr_q;
    str_d    = str_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      GS_MENU: begin
        if (start) begin
          state_d  = GS_SHOW;
          tmr_load = 1'b1;
          px_d     = XW'(START_X);
          py_d     = YW'(START_Y);
          str_d    = '0;
          mv_d     = MV_IDLE;
        end
      end
      GS_SHOW: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = GS_PLAY;
      end
      GS_PLAY: begin
        case (mv_q)
          MV_IDLE: begin
            if (cand_ok) begin
              tx_d   = cand_x[XW-1:0];
              ty_d   = cand_y[YW-1:0];
              addr_d = cand_y[YW-1:0];
              mv_d   = MV_WAIT;
            end
          end
          MV_WAIT: mv_d = MV_CHECK;
          MV_CHECK: begin
            mv_d = MV_IDLE;
            if (map_row[tx_q]) begin
              str_d = (str_q == STR_MAX) ? str_q : str_q + 1'b1;
              if (str_d == STR_MAX) state_d = GS_LOST;
            end else begin
              px_d = tx_q;
              py_d = ty_q;
              if ((tx_q == XW'(GOAL_X)) && (ty_q == YW'(GOAL_Y))) state_d = GS_WON;
            end
          end
          default: mv_d = MV_IDLE;
        endcase
      end
      GS_WON, GS_LOST: begin
        if (start) begin
          state_d = GS_MENU;
          px_d    = XW'(START_X);
          py_d    = YW'(START_Y);
          str_d   = '0;
        end
      end
      default: state_d = GS_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= GS_MENU;
      mv_q    <= MV_IDLE;
      px_q    <= XW'(START_X);
      py_q    <= YW'(START_Y);
      tx_q    <= '0;
      ty_q    <= '0;
      addr_q  <= '0;
      str_q   <= '0;
      show_q  <= 1'b0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mv_q    <= mv_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      addr_q  <= addr_d;
      str_q   <= str_d;
      show_q  <= (state_d == GS_SHOW);
      won_q   <= (state_d == GS_WON);
      lost_q  <= (state_d == GS_LOST);
    end
  end

  assign map_addr       = addr_q;
  assign player_x       = px_q;
  assign player_y       = py_q;
  assign show_map       = show_q;
  assign game_state     = state_q;
  assign strikes        = str_q;
  assign won            = won_q;
  assign lost           = lost_q;
  assign move_state_dbg = mv_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Bench for maze_game_ctrl: directed vector table then random play against a game model.
module tb_maze_game_ctrl;

  localparam int MAP_W = 8;
  localparam int MAP_H = 6;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] difficulty;
  logic [3:0] scen;
  logic [2:0] map_addr;
  logic [7:0] map_row;
  logic [2:0] player_x, player_y;
  logic       show_map;
  logic [2:0] game_state;
  logic [1:0] strikes;
  logic       won, lost;
  logic [1:0] move_state_dbg;

  always #5 clk = ~clk;

  maze_game_ctrl #(
    .MAP_W(8), .MAP_H(6), .START_X(0), .START_Y(3), .GOAL_X(7), .GOAL_Y(3),
    .MAX_STRIKES(2), .SHOW_EASY(10), .SHOW_MED(5), .SHOW_HARD(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .difficulty(difficulty), .scen(scen),
    .map_addr(map_addr), .map_row(map_row), .player_x(player_x), .player_y(player_y),
    .show_map(show_map), .game_state(game_state), .strikes(strikes),
    .won(won), .lost(lost), .move_state_dbg(move_state_dbg)
  );

  // Maze: bit[x]=1 is a wall. Goal (7,3) open, wall at (2,3).
  logic [7:0] rom [0:5];
  initial begin
    rom[0] = 8'h00;
    rom[1] = 8'h08;
    rom[2] = 8'h20;
    rom[3] = 8'h24;
    rom[4] = 8'h00;
    rom[5] = 8'h81;
  end

  always @(posedge clk) map_row <= (map_addr < 3'd6) ? rom[map_addr] : 8'h00;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model: tracks position, strikes, preview cycles left and an in-flight move.
  int m_st, m_x, m_y, m_str, m_show_left, m_pend, m_tx, m_ty;
  int show_len [4] = '{10, 5, 2, 2};

  task automatic model_step(input logic s, input logic [1:0] d, input logic [3:0] sc, input logic rn);
    int dir, nx, ny;
    if (!rn) begin
      m_st = 0; m_x = 0; m_y = 3; m_str = 0; m_show_left = 0; m_pend = 0;
    end else begin
      case (m_st)
        0: if (s) begin
          m_st = 1; m_show_left = show_len[d]; m_x = 0; m_y = 3; m_str = 0; m_pend = 0;
        end
        1: begin
          m_show_left--;
          if (m_show_left == 0) m_st = 2;
        end
        2: begin
          if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
              if (rom[m_ty][m_tx]) begin
                if (m_str < 2) m_str++;
                if (m_str == 2) m_st = 4;
              end else begin
                m_x = m_tx; m_y = m_ty;
                if (m_x == 7 && m_y == 3) m_st = 3;
              end
            end
          end else if (sc != 4'd0) begin
            dir = 0;
            for (int i = 3; i >= 0; i--) if (sc[i]) dir = i;
            nx = m_x; ny = m_y;
            case (dir)
              0: ny = m_y - 1;
              1: ny = m_y + 1;
              2: nx = m_x - 1;
              default: nx = m_x + 1;
            endcase
            if (nx >= 0 && nx < MAP_W && ny >= 0 && ny < MAP_H) begin
              m_tx = nx; m_ty = ny; m_pend = 2;
            end
          end
        end
        default: if (s) begin
          m_st = 0; m_x = 0; m_y = 3; m_str = 0;
        end
      endcase
    end
  endtask

  task automatic tick(input logic s, input logic [1:0] d, input logic [3:0] sc, input logic rn);
    start = s; difficulty = d; scen = sc; reset = rn;
    @(posedge clk);
    model_step(s, d, sc, rn);
    @(negedge clk);
    start = 1'b0; scen = 4'd0; reset = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input int st, input int x, input int y, input int str);
    chk({tag, ".state"}, 32'(game_state), st);
    chk({tag, ".x"}, 32'(player_x), x);
    chk({tag, ".y"}, 32'(player_y), y);
    chk({tag, ".strikes"}, 32'(strikes), str);
    chk({tag, ".show_map"}, 32'(show_map), (st == 1) ? 1 : 0);
    chk({tag, ".won"}, 32'(won), (st == 3) ? 1 : 0);
    chk({tag, ".lost"}, 32'(lost), (st == 4) ? 1 : 0);
  endtask

  typedef struct {
    logic       st;
    logic [1:0] d;
    logic [3:0] sc;
    logic       rn;
    int         e_state, e_x, e_y, e_str;
  } vec_t;

  vec_t vq[$];

  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LF = 4'b0100, RT = 4'b1000;

  task automatic add(input logic s, input logic [1:0] d, input logic [3:0] sc, input logic rn,
                     input int es, input int ex, input int ey, input int estr);
    vec_t v;
    v.st = s; v.d = d; v.sc = sc; v.rn = rn;
    v.e_state = es; v.e_x = ex; v.e_y = ey; v.e_str = estr;
    vq.push_back(v);
  endtask

  // A move occupies three edges; the result appears after the third.
  task automatic add_move(input logic [3:0] sc, input int x0, input int y0, input int s0,
                          input int x1, input int y1, input int s1, input int fin);
    add(1'b0, 2'd0, sc,   1'b1, 2, x0, y0, s0);
    add(1'b0, 2'd0, 4'd0, 1'b1, 2, x0, y0, s0);
    add(1'b0, 2'd0, 4'd0, 1'b1, fin, x1, y1, s1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; difficulty = 2'd0; scen = 4'd0;

    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 1, 1, 0, 3, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(1, 1, 0, 1, 1, 0, 3, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0);
    add(1, 0, RT, 1, 1, 0, 3, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0);
    add(0, 0, 0, 1, 2, 0, 3, 0);
    add_move(RT, 0, 3, 0, 1, 3, 0, 2);
    add_move(UP, 1, 3, 0, 1, 2, 0, 2);
    add_move(UP, 1, 2, 0, 1, 1, 0, 2);
    add_move(UP, 1, 1, 0, 1, 0, 0, 2);
    add(0, 0, UP, 1, 2, 1, 0, 0);
    add_move(DN, 1, 0, 0, 1, 1, 0, 2);
    add(0, 0, UP | LF, 1, 2, 1, 1, 0);
    add(0, 0, RT, 1, 2, 1, 1, 0);
    add(0, 0, 0, 1, 2, 1, 0, 0);
    add(0, 0, 0, 1, 2, 1, 0, 0);
    add(0, 0, 0, 1, 2, 1, 0, 0);
    add_move(DN, 1, 0, 0, 1, 1, 0, 2);
    add_move(DN, 1, 1, 0, 1, 2, 0, 2);
    add_move(DN, 1, 2, 0, 1, 3, 0, 2);
    add_move(RT, 1, 3, 0, 1, 3, 1, 2);
    add_move(RT, 1, 3, 1, 1, 3, 2, 4);
    add(0, 0, RT, 1, 4, 1, 3, 2);
    add(0, 0, UP, 1, 4, 1, 3, 2);
    add(1, 0, 0, 1, 0, 0, 3, 0);
    add(1, 2, 0, 1, 1, 0, 3, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0);
    add(0, 0, 0, 1, 2, 0, 3, 0);
    add_move(RT, 0, 3, 0, 1, 3, 0, 2);
    add_move(DN, 1, 3, 0, 1, 4, 0, 2);
    for (int x = 1; x <= 6; x++) add_move(RT, x, 4, 0, x + 1, 4, 0, 2);
    add_move(UP, 7, 4, 0, 7, 3, 0, 3);
    add(0, 0, LF, 1, 3, 7, 3, 0);
    add(1, 0, 0, 1, 0, 0, 3, 0);

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].st, vq[i].d, vq[i].sc, vq[i].rn);
      check_outputs($sformatf("vec%0d", i), vq[i].e_state, vq[i].e_x, vq[i].e_y, vq[i].e_str);
    end

    for (int i = 0; i < 3000; i++) begin
      logic       s, rn;
      logic [1:0] d;
      logic [3:0] sc;
      s  = ($urandom_range(0, 39) == 0);
      d  = 2'($urandom_range(0, 3));
      sc = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      rn = ($urandom_range(0, 299) != 0);
      tick(s, d, sc, rn);
      check_outputs($sformatf("rnd%0d", i), m_st, m_x, m_y, m_str);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
